shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 19 +
 rtl/shift_sequencer_if.sv | 18 +
 rtl/shift_sequencer_step_sel.sv | 19 +
 rtl/shift_sequencer.sv | 66 ++++++
 tb/tb_shift_sequencer.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: op encodings, ALU control codes and FSM state type
package shift_sequencer_pkg;
  typedef enum logic [1:0] {OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_RSV = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
  localparam logic [5:0] CTRL_NOP  = 6'h00;
  localparam logic [5:0] CTRL_SLL1 = 6'h0A;
  localparam logic [5:0] CTRL_SLL2 = 6'h0B;
  localparam logic [5:0] CTRL_SLL8 = 6'h0C;
  localparam logic [5:0] CTRL_SRL1 = 6'h0D;
  localparam logic [5:0] CTRL_SRL2 = 6'h0E;
  localparam logic [5:0] CTRL_SRL8 = 6'h0F;
  localparam logic [5:0] CTRL_SRA1 = 6'h10;
  localparam logic [5:0] CTRL_SRA2 = 6'h11;
  localparam logic [5:0] CTRL_SRA8 = 6'h12;
  // largest step not exceeding the remaining count, so rem never underflows
  function automatic logic [4:0] step_of(logic [4:0] rem);
    return rem >= 5'd8 ? 5'd8 : rem >= 5'd2 ? 5'd2 : 5'd1;
  endfunction
endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/response and external ALU signals of the sequencer
interface shift_sequencer_if;
  logic        start;
  logic [1:0]  op;
  logic [4:0]  shamt;
  logic [31:0] operand;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [5:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  modport master (output start, op, shamt, operand, alu_r,
                  input  busy, done, result, alu_ctrl, alu_a, alu_b);
  modport slave  (input  start, op, shamt, operand, alu_r,
                  output busy, done, result, alu_ctrl, alu_a, alu_b);
endinterface

// File: rtl/shift_sequencer_step_sel.sv
// shift_step_sel: picks the next shift step and the matching ALU control code
module shift_step_sel
  import shift_sequencer_pkg::*;
(
  input  logic [4:0] rem,
  input  logic [1:0] op,
  output logic [4:0] step,
  output logic [5:0] ctrl
);
  logic [5:0] w_ofs;
  // codes are contiguous per op in step order 1,2,8, so offset from the x1 code
  always_comb begin
    step  = step_of(rem);
    w_ofs = step == 5'd8 ? 6'd2 : step == 5'd2 ? 6'd1 : 6'd0;
    ctrl  = op == OP_SLL ? CTRL_SLL1 + w_ofs :
            op == OP_SRL ? CTRL_SRL1 + w_ofs :
            op == OP_SRA ? CTRL_SRA1 + w_ofs : CTRL_NOP;
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift driven through an external ALU in steps of 8/2/1
module shift_sequencer
  import shift_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  shift_sequencer_if.slave   bus
);
  state_e      r_state, w_state_nxt;
  logic [31:0] r_acc, w_acc_nxt, r_result;
  logic [4:0]  r_rem, w_rem_nxt, w_step;
  logic [1:0]  r_op, w_op_nxt;
  logic [5:0]  w_ctrl;
  shift_step_sel u_step_sel (
    .rem  (r_rem),
    .op   (r_op),
    .step (w_step),
    .ctrl (w_ctrl)
  );
  // next-state logic: latch request in IDLE, consume one ALU step per SHIFT cycle
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_rem_nxt   = r_rem;
    w_op_nxt    = r_op;
    case (r_state)
      S_IDLE: if (bus.start) begin
        w_acc_nxt   = bus.operand;
        w_rem_nxt   = bus.shamt;
        w_op_nxt    = bus.op;
        w_state_nxt = (bus.shamt != 5'd0 && bus.op != OP_RSV) ? S_SHIFT : S_DONE;
      end
      S_SHIFT: begin
        w_acc_nxt   = bus.alu_r;
        w_rem_nxt   = r_rem - w_step;
        w_state_nxt = (r_rem == w_step) ? S_DONE : S_SHIFT;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // state registers; result is captured on entry to DONE so it is valid with the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_rem    <= '0;
      r_op     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_rem   <= w_rem_nxt;
      r_op    <= w_op_nxt;
      if (w_state_nxt == S_DONE) r_result <= w_acc_nxt;
    end
  end
  // outputs: ALU is only driven while shifting
  always_comb begin
    bus.busy     = r_state != S_IDLE;
    bus.done     = r_state == S_DONE;
    bus.result   = r_result;
    bus.alu_a    = '0;
    bus.alu_b    = r_state == S_SHIFT ? r_acc : '0;
    bus.alu_ctrl = r_state == S_SHIFT ? w_ctrl : CTRL_NOP;
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: scoreboard bench coupling the sequencer to a behavioural ALU
module tb_shift_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic [31:0] last_res;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_sequencer_if bus();
  shift_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic logic [31:0] alu(logic [5:0] c, logic [31:0] a, logic [31:0] b);
    case (c)
      6'h0A: return b << 1;
      6'h0B: return b << 2;
      6'h0C: return b << 8;
      6'h0D: return b >> 1;
      6'h0E: return b >> 2;
      6'h0F: return b >> 8;
      6'h10: return 32'($signed(b) >>> 1);
      6'h11: return 32'($signed(b) >>> 2);
      6'h12: return 32'($signed(b) >>> 8);
      default: return a + b;
    endcase
  endfunction
  assign bus.alu_r = alu(bus.alu_ctrl, bus.alu_a, bus.alu_b);

  typedef struct {
    logic [31:0] res;
    int          n;
    int          t0;
    logic [41:0] seq;
  } exp_t;
  exp_t exp_q[$];
  logic [5:0] obs[$];

  // reference: result by direct shift, step list by greedy 8/2/1 decomposition
  function automatic exp_t model(logic [1:0] op, logic [4:0] s, logic [31:0] v);
    exp_t e;
    int n8, n2, n1;
    logic [5:0] base;
    e.res = op == 2'd0 ? v << s : op == 2'd1 ? v >> s : op == 2'd2 ? 32'($signed(v) >>> s) : v;
    n8 = int'(s) / 8;
    n2 = (int'(s) % 8) / 2;
    n1 = int'(s) % 2;
    e.n = op == 2'd3 ? 0 : n8 + n2 + n1;
    e.t0 = 0;
    e.seq = '0;
    base = op == 2'd0 ? 6'h0A : op == 2'd1 ? 6'h0D : 6'h10;
    for (int i = 0; i < e.n; i++)
      e.seq[6*i +: 6] = base + (i < n8 ? 6'd2 : i < n8 + n2 ? 6'd1 : 6'd0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // monitor: idle-time ALU quiet checks and scoreboard pop on every done pulse
  always @(negedge clk) begin
    if (!rst_n) obs.delete();
    else begin
      if (bus.alu_ctrl != 6'h00) obs.push_back(bus.alu_ctrl);
      if (!bus.busy) chk("idle_quiet", {bus.done, bus.alu_ctrl, bus.alu_b, bus.alu_a}, '0);
      if (bus.done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
        else begin
          exp_t e;
          logic [41:0] got;
          e = exp_q.pop_front();
          got = '0;
          for (int i = 0; i < obs.size() && i < 7; i++) got[6*i +: 6] = obs[i];
          chk("result", bus.result, e.res);
          chk("latency", cyc - e.t0 + 1, e.n + 1);
          chk("ctrl_count", obs.size(), e.n);
          chk("ctrl_seq", got, e.seq);
        end
        obs.delete();
      end
    end
  end

  // present a request, hold start until an IDLE edge accepts it, then push its expectation
  task automatic issue(input logic [1:0] op, input logic [4:0] s, input logic [31:0] v, input bit noise);
    exp_t e;
    bit idle;
    int g = 0;
    bus.op = op;
    bus.shamt = s;
    bus.operand = v;
    bus.start = 1'b1;
    do begin
      idle = !bus.busy;
      @(posedge clk);
      #1;
      g++;
    end while (!idle && g < 50);
    if (!idle) begin
      chk("accept_timeout", 64'd0, 64'd1);
      bus.start = 1'b0;
      return;
    end
    e = model(op, s, v);
    e.t0 = cyc;
    exp_q.push_back(e);
    last_res = e.res;
    bus.start = 1'b0;
    if (noise) begin
      bus.op = 2'($urandom);
      bus.shamt = 5'($urandom);
      bus.operand = ~v;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || bus.busy) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain", {31'd0, bus.busy, 32'(exp_q.size())}, 64'd0);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = '0;
    bus.shamt = '0;
    bus.operand = '0;
    #2;
    chk("reset_outputs", {bus.busy, bus.done, bus.result, bus.alu_ctrl}, '0);
    chk("reset_alu_b", bus.alu_b, 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2'd0, 5'd31, 32'h0000_0001, 1'b0);
    issue(2'd2, 5'd9,  32'h8000_0000, 1'b0);
    issue(2'd1, 5'd4,  32'hF000_0000, 1'b0);
    issue(2'd1, 5'd0,  32'h1234_5678, 1'b0);
    issue(2'd3, 5'd17, 32'hDEAD_BEEF, 1'b0);
    issue(2'd1, 5'd20, 32'hAAAA_5555, 1'b1);
    issue(2'd3, 5'd0,  32'h0BAD_F00D, 1'b1);
    drain();
    repeat (3) @(posedge clk);
    #1 chk("result_held", bus.result, last_res);
    issue(2'd0, 5'd5, 32'h0000_0007, 1'b0);
    begin
      int g = 0;
      while (!bus.done && g < 20) begin
        @(negedge clk);
        g++;
      end
      chk("done_seen", bus.done, 1'b1);
    end
    issue(2'd2, 5'd3, 32'h8000_0001, 1'b0);
    drain();
    issue(2'd0, 5'd31, 32'h0000_0001, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {bus.busy, bus.done, bus.result, bus.alu_ctrl}, '0);
    chk("abort_alu_b", bus.alu_b, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(2'd0, 5'd2, 32'h0000_0003, 1'b0);
    drain();
    chk("post_reset_result", bus.result, 64'h0000_000C);
    for (int k = 0; k < 60; k++) begin
      issue(2'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
